// File: rtl/dm_wb_cache_pkg.sv
// dm_wb_cache_pkg: shared types and constants for the direct-mapped write-back cache.
//   cache_state_e    : controller states IDLE / SWAP_OUT / SWAP_IN / SWAP_IN_OK
//   DEF_*_ADDR_LEN   : default address-field widths (line word index, set index, tag)
//   LINE_SIZE        : words per line for the default geometry
//   SET_SIZE         : number of sets for the default geometry
//   word_lsb/set_lsb/tag_lsb : bit positions of the fields inside a CPU byte address
package dm_wb_cache_pkg;

  localparam int unsigned DEF_LINE_ADDR_LEN = 3;
  localparam int unsigned DEF_SET_ADDR_LEN  = 2;
  localparam int unsigned DEF_TAG_ADDR_LEN  = 6;

  localparam int unsigned LINE_SIZE = 1 << DEF_LINE_ADDR_LEN;
  localparam int unsigned SET_SIZE  = 1 << DEF_SET_ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE,
    SWAP_OUT,
    SWAP_IN,
    SWAP_IN_OK
  } cache_state_e;

  // Byte offset occupies cpu_addr[1:0]; the word index starts right above it.
  function automatic int unsigned word_lsb();
    return 2;
  endfunction

  function automatic int unsigned set_lsb(input int unsigned line_addr_len);
    return line_addr_len + 2;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned line_addr_len,
                                          input int unsigned set_addr_len);
    return line_addr_len + set_addr_len + 2;
  endfunction

endpackage

// File: rtl/dm_wb_cache_if.sv
// dm_wb_cache_if: CPU load/store port plus main_mem line port of the cache.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU access request
//   cpu_rdata/cpu_miss                : load data and stall
//   mem_addr/mem_rd_req/mem_wr_req    : line request towards main_mem
//   mem_wr_line                       : writeback line
//   mem_gnt/mem_rd_line               : main_mem grant and refill line
// Modports: slave = the cache itself, master = the CPU + main_mem environment.
interface dm_wb_cache_if #(
  parameter int unsigned LINE_ADDR_LEN = dm_wb_cache_pkg::DEF_LINE_ADDR_LEN,
  parameter int unsigned SET_ADDR_LEN  = dm_wb_cache_pkg::DEF_SET_ADDR_LEN,
  parameter int unsigned TAG_ADDR_LEN  = dm_wb_cache_pkg::DEF_TAG_ADDR_LEN
);

  logic                                          cpu_req;
  logic                                          cpu_we;
  logic [31:0]                                   cpu_addr;
  logic [31:0]                                   cpu_wdata;
  logic [31:0]                                   cpu_rdata;
  logic                                          cpu_miss;

  logic                                          mem_gnt;
  logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]          mem_addr;
  logic                                          mem_rd_req;
  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]           mem_rd_line;
  logic                                          mem_wr_req;
  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]           mem_wr_line;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_gnt, mem_rd_line,
    output cpu_rdata, cpu_miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_gnt, mem_rd_line,
    input  cpu_rdata, cpu_miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line
  );

endinterface

// File: rtl/dm_wb_cache_store.sv
// dm_cache_store: data/tag/valid/dirty arrays of the direct-mapped cache.
//   clk, rst                       : clock, asynchronous active-high reset (valid/dirty only)
//   rd_set -> rd_line/rd_tag/rd_valid/rd_dirty : combinational read port
//   line_we/line_set/line_tag/line_data        : refill write (sets valid, clears dirty)
//   word_we/word_set/word_idx/word_data        : store-hit write (sets dirty)
//   clean_we/clean_set                         : clears dirty after writeback
module dm_cache_store #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned SET_ADDR_LEN  = 2,
  parameter int unsigned TAG_ADDR_LEN  = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [SET_ADDR_LEN-1:0]               rd_set,
  output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   rd_line,
  output logic [TAG_ADDR_LEN-1:0]               rd_tag,
  output logic                                  rd_valid,
  output logic                                  rd_dirty,
  input  logic                                  line_we,
  input  logic [SET_ADDR_LEN-1:0]               line_set,
  input  logic [TAG_ADDR_LEN-1:0]               line_tag,
  input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   line_data,
  input  logic                                  word_we,
  input  logic [SET_ADDR_LEN-1:0]               word_set,
  input  logic [LINE_ADDR_LEN-1:0]              word_idx,
  input  logic [31:0]                           word_data,
  input  logic                                  clean_we,
  input  logic [SET_ADDR_LEN-1:0]               clean_set
);

  localparam int unsigned WORDS = 1 << LINE_ADDR_LEN;
  localparam int unsigned SETS  = 1 << SET_ADDR_LEN;

  logic [WORDS-1:0][31:0]  data [SETS];
  logic [TAG_ADDR_LEN-1:0] tags [SETS];
  logic [SETS-1:0]         valid;
  logic [SETS-1:0]         dirty;

  assign rd_line  = data[rd_set];
  assign rd_tag   = tags[rd_set];
  assign rd_valid = valid[rd_set];
  assign rd_dirty = dirty[rd_set];

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data[line_set] <= line_data;
      tags[line_set] <= line_tag;
    end else if (word_we) begin
      data[word_set][word_idx] <= word_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (line_we) begin
        valid[line_set] <= 1'b1;
        dirty[line_set] <= 1'b0;
      end
      if (clean_we) dirty[clean_set] <= 1'b0;
      if (word_we)  dirty[word_set]  <= 1'b1;
    end
  end

endmodule

// File: rtl/dm_wb_cache.sv
// dm_wb_cache: direct-mapped, write-back, write-allocate data cache.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : dm_wb_cache_if.slave (CPU load/store port + main_mem line port)
//   stat_hit   : hit counter (CACHE_STATS_EN defined), else tied to 0
//   stat_miss  : miss counter (CACHE_STATS_EN defined), else tied to 0
// Hits complete in the request cycle; a miss stalls through an optional
// writeback (SWAP_OUT) and a refill (SWAP_IN, SWAP_IN_OK), after which the
// access hits in IDLE. Optional feature macro: CACHE_STATS_EN.
module dm_wb_cache
  import dm_wb_cache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int unsigned SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
  parameter int unsigned TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN
) (
  input  logic          clk,
  input  logic          rst,
  dm_wb_cache_if.slave  bus,
  output logic [31:0]   stat_hit,
  output logic [31:0]   stat_miss
);

  localparam int unsigned WORDS    = 1 << LINE_ADDR_LEN;
  localparam int unsigned WORD_LSB = word_lsb();
  localparam int unsigned SET_LSB  = set_lsb(LINE_ADDR_LEN);
  localparam int unsigned TAG_LSB  = tag_lsb(LINE_ADDR_LEN, SET_ADDR_LEN);
  localparam int unsigned ADDR_TOP = TAG_LSB + TAG_ADDR_LEN;

  logic [LINE_ADDR_LEN-1:0] cpu_word;
  logic [SET_ADDR_LEN-1:0]  cpu_set;
  logic [TAG_ADDR_LEN-1:0]  cpu_tag;
  logic                     unused_addr;

  assign cpu_word    = bus.cpu_addr[WORD_LSB +: LINE_ADDR_LEN];
  assign cpu_set     = bus.cpu_addr[SET_LSB +: SET_ADDR_LEN];
  assign cpu_tag     = bus.cpu_addr[TAG_LSB +: TAG_ADDR_LEN];
  assign unused_addr = ^{bus.cpu_addr[WORD_LSB-1:0], bus.cpu_addr[31:ADDR_TOP]};

  cache_state_e                         state;
  logic [TAG_ADDR_LEN-1:0]              miss_tag;
  logic [SET_ADDR_LEN-1:0]              miss_set;
  logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr_q;
  logic                                 rd_req_q;
  logic                                 wr_req_q;

  logic [SET_ADDR_LEN-1:0]  rd_set;
  logic [WORDS-1:0][31:0]   rd_line;
  logic [TAG_ADDR_LEN-1:0]  rd_tag;
  logic                     rd_valid;
  logic                     rd_dirty;
  logic                     hit;
  logic                     line_we;
  logic                     word_we;
  logic                     clean_we;

  // The miss address is latched so an in-flight transaction still finishes
  // correctly if the CPU drops or changes its request mid-miss.
  assign rd_set   = (state == IDLE) ? cpu_set : miss_set;
  assign hit      = bus.cpu_req && (state == IDLE) && rd_valid && (rd_tag == cpu_tag);
  assign line_we  = (state == SWAP_IN_OK);
  assign word_we  = hit && bus.cpu_we;
  assign clean_we = (state == SWAP_OUT) && wr_req_q && bus.mem_gnt;

  dm_cache_store #(
    .LINE_ADDR_LEN (LINE_ADDR_LEN),
    .SET_ADDR_LEN  (SET_ADDR_LEN),
    .TAG_ADDR_LEN  (TAG_ADDR_LEN)
  ) store (
    .clk       (clk),
    .rst       (rst),
    .rd_set    (rd_set),
    .rd_line   (rd_line),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .line_we   (line_we),
    .line_set  (miss_set),
    .line_tag  (miss_tag),
    .line_data (bus.mem_rd_line),
    .word_we   (word_we),
    .word_set  (cpu_set),
    .word_idx  (cpu_word),
    .word_data (bus.cpu_wdata),
    .clean_we  (clean_we),
    .clean_set (miss_set)
  );

  assign bus.cpu_miss    = bus.cpu_req && !hit;
  assign bus.cpu_rdata   = (hit && !bus.cpu_we) ? rd_line[cpu_word] : '0;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd_req  = rd_req_q;
  assign bus.mem_wr_req  = wr_req_q;
  assign bus.mem_wr_line = rd_line;

  // Each request is raised only on the second cycle in its state, so the
  // address is stable beforehand and requests are low for at least one cycle
  // between writeback and refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      miss_tag   <= '0;
      miss_set   <= '0;
      mem_addr_q <= '0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req && !hit) begin
            miss_tag <= cpu_tag;
            miss_set <= cpu_set;
            if (rd_valid && rd_dirty) begin
              state      <= SWAP_OUT;
              mem_addr_q <= {rd_tag, cpu_set};
            end else begin
              state      <= SWAP_IN;
              mem_addr_q <= {cpu_tag, cpu_set};
            end
          end
        end
        SWAP_OUT: begin
          if (!wr_req_q) begin
            wr_req_q <= 1'b1;
          end else if (bus.mem_gnt) begin
            wr_req_q   <= 1'b0;
            state      <= SWAP_IN;
            mem_addr_q <= {miss_tag, miss_set};
          end
        end
        SWAP_IN: begin
          if (!rd_req_q) begin
            rd_req_q <= 1'b1;
          end else if (bus.mem_gnt) begin
            rd_req_q <= 1'b0;
            state    <= SWAP_IN_OK;
          end
        end
        SWAP_IN_OK: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // A hit after a refill completes an access that was already counted as a miss.
  logic miss_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit     <= '0;
      stat_miss    <= '0;
      miss_pending <= 1'b0;
    end else if ((state == IDLE) && bus.cpu_req && !hit) begin
      if (stat_miss != '1) stat_miss <= stat_miss + 32'd1;
      miss_pending <= 1'b1;
    end else if (hit) begin
      if (!miss_pending && (stat_hit != '1)) stat_hit <= stat_hit + 32'd1;
      miss_pending <= 1'b0;
    end else if ((state == IDLE) && !bus.cpu_req) begin
      miss_pending <= 1'b0;
    end
  end
`else
  assign stat_hit  = '0;
  assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_dm_wb_cache.sv
// tb_dm_wb_cache: self-checking bench for dm_wb_cache paired with a
// behavioural main_mem (word[i]=i, grant after 5 request cycles, refill line
// valid the cycle after grant). Directed vector table, hand sequences for
// mid-miss request drop and mid-miss reset, then random accesses checked
// against a golden word memory and a per-set resident-line model.
// Stats expectations follow CACHE_STATS_EN.
module tb_dm_wb_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;

  dm_wb_cache_if bus ();

  dm_wb_cache #(
    .LINE_ADDR_LEN (3),
    .SET_ADDR_LEN  (2),
    .TAG_ADDR_LEN  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural main_mem ----------------
  logic [31:0]      mem [0:2047];
  logic             loaded = 1'b0;
  int unsigned      cnt = 0;
  logic [7:0][31:0] line_q;
  int unsigned      rd_total = 0;
  int unsigned      wr_total = 0;
  logic [7:0]       last_rd_addr = '0;
  logic [7:0]       last_wr_addr = '0;
  logic [7:0][31:0] last_wr_line = '0;

  assign bus.mem_gnt     = (bus.mem_rd_req || bus.mem_wr_req) && (cnt == 5);
  assign bus.mem_rd_line = line_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      if (!loaded) begin
        for (int i = 0; i < 2048; i++) mem[i] <= 32'(i);
        loaded <= 1'b1;
      end
    end else begin
      if (!(bus.mem_rd_req || bus.mem_wr_req) || bus.mem_gnt) cnt <= 0;
      else cnt <= cnt + 1;
      if (bus.mem_gnt && bus.mem_rd_req) begin
        for (int w = 0; w < 8; w++) line_q[w] <= mem[{bus.mem_addr, 3'(w)}];
        rd_total     <= rd_total + 1;
        last_rd_addr <= bus.mem_addr;
      end
      if (bus.mem_gnt && bus.mem_wr_req) begin
        for (int w = 0; w < 8; w++) mem[{bus.mem_addr, 3'(w)}] <= bus.mem_wr_line[w];
        wr_total     <= wr_total + 1;
        last_wr_addr <= bus.mem_addr;
        last_wr_line <= bus.mem_wr_line;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        p_rd = 1'b0;
  logic        p_wr = 1'b0;
  logic [7:0]  p_addr = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int unsigned act,
                             input int unsigned lo, input int unsigned hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance to the next falling edge and check the memory-side protocol there.
  task automatic cyc();
    @(negedge clk);
    if (rst) begin
      p_rd = 1'b0;
      p_wr = 1'b0;
    end else begin
      if (bus.mem_rd_req || bus.mem_wr_req) begin
        n_checks++;
        if ((bus.mem_rd_req && bus.mem_wr_req) ||
            ((p_rd || p_wr) && bus.mem_addr != p_addr) ||
            (bus.mem_rd_req && p_wr) || (bus.mem_wr_req && p_rd)) begin
          n_fail++;
          $display("FAIL mem_protocol: rd=%b wr=%b addr=%h prev rd=%b wr=%b addr=%h",
                   bus.mem_rd_req, bus.mem_wr_req, bus.mem_addr, p_rd, p_wr, p_addr);
        end
      end
      p_rd   = bus.mem_rd_req;
      p_wr   = bus.mem_wr_req;
      p_addr = bus.mem_addr;
    end
  endtask

  // One CPU access, called at a falling edge; returns at a falling edge with cpu_req low.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output bit missed,
                           output int unsigned stall, output int unsigned nrd,
                           output int unsigned nwr);
    int unsigned rd0;
    int unsigned wr0;
    rd0 = rd_total;
    wr0 = wr_total;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    stall = 0;
    #1;
    while (bus.cpu_miss && stall < 100) begin
      stall++;
      cyc();
      #1;
    end
    check32("access_done", 32'(bus.cpu_miss), 32'd0);
    rdata  = bus.cpu_rdata;
    missed = (stall != 0);
    cyc();
    bus.cpu_req = 1'b0;
    nrd = rd_total - rd0;
    nwr = wr_total - wr0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_miss;
    int unsigned exp_stall;
    int unsigned exp_nrd;
    logic [7:0]  exp_rd_addr;
    int unsigned exp_nwr;
    logic [7:0]  exp_wr_addr;
    bit          chk_w1;
    logic [31:0] exp_w1;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // Random-phase reference: golden word memory and which line each set holds.
  logic [31:0] golden [0:2047];
  bit          rv [4];
  logic [7:0]  rl [4];
  bit          rdty [4];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    bit          missed;
    int unsigned stall, nrd, nwr, k;
    int unsigned exp_hits, exp_misses;

    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0,          1'b1, 9,  1, 8'h00, 0, 8'h00, 1'b0, 32'h0,          32'h0000_0001};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,          1'b0, 0,  0, 8'h00, 0, 8'h00, 1'b0, 32'h0,          32'h0000_0001};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF,  1'b0, 0,  0, 8'h00, 0, 8'h00, 1'b0, 32'h0,          32'h0};
    vecs[3] = '{1'b0, 32'h0000_0084, 32'h0,          1'b1, 16, 1, 8'h04, 1, 8'h00, 1'b1, 32'hDEAD_BEEF,  32'h0000_0021};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h1234_5678,  1'b1, 9,  1, 8'h01, 0, 8'h00, 1'b0, 32'h0,          32'h0};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,          1'b0, 0,  0, 8'h00, 0, 8'h00, 1'b0, 32'h0,          32'h1234_5678};

    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check32("rst_cpu_miss",  32'(bus.cpu_miss),   32'd0);
    check32("rst_rd_req",    32'(bus.mem_rd_req), 32'd0);
    check32("rst_wr_req",    32'(bus.mem_wr_req), 32'd0);
    check32("rst_mem_addr",  32'(bus.mem_addr),   32'd0);
    check32("rst_cpu_rdata", bus.cpu_rdata,       32'd0);
    check32("rst_stat_hit",  stat_hit,            32'd0);
    check32("rst_stat_miss", stat_miss,           32'd0);
    cyc();

    // Directed table.
    exp_hits = 0;
    exp_misses = 0;
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, missed, stall, nrd, nwr);
      if (vecs[i].exp_miss) exp_misses++;
      else exp_hits++;
      check32($sformatf("v%0d_miss", i), 32'(missed), 32'(vecs[i].exp_miss));
      check32($sformatf("v%0d_nrd", i), nrd, vecs[i].exp_nrd);
      check32($sformatf("v%0d_nwr", i), nwr, vecs[i].exp_nwr);
      if (vecs[i].exp_stall == 0) check32($sformatf("v%0d_stall", i), stall, 0);
      else check_range($sformatf("v%0d_stall", i), stall, vecs[i].exp_stall - 1, vecs[i].exp_stall + 1);
      if (vecs[i].exp_nrd != 0) check32($sformatf("v%0d_rd_addr", i), 32'(last_rd_addr), 32'(vecs[i].exp_rd_addr));
      if (vecs[i].exp_nwr != 0) check32($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].exp_wr_addr));
      if (vecs[i].chk_w1) check32($sformatf("v%0d_wr_line1", i), last_wr_line[1], vecs[i].exp_w1);
      if (!vecs[i].we) check32($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Request dropped mid-miss: refill still completes and the line is installed.
    k = rd_total;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h0000_0060;
    repeat (3) cyc();
    bus.cpu_req = 1'b0;
    bus.cpu_addr = 32'hFFFF_FFFC;
    nrd = 0;
    while (rd_total == k && nrd < 60) begin
      cyc();
      nrd++;
    end
    check32("drop_refill_done", rd_total - k, 1);
    exp_misses++;
    cyc();
    cyc();
    #1;
    check32("drop_idle_miss", 32'(bus.cpu_miss), 32'd0);
    do_access(1'b0, 32'h0000_0060, 32'h0, rdata, missed, stall, nrd, nwr);
    exp_hits++;
    check32("drop_hit_miss", 32'(missed), 32'd0);
    check32("drop_hit_rdata", rdata, 32'h0000_0018);
    check32("drop_hit_nrd", nrd, 0);

`ifdef CACHE_STATS_EN
    check32("dir_stat_hit",  stat_hit,  exp_hits);
    check32("dir_stat_miss", stat_miss, exp_misses);
`else
    check32("dir_stat_hit",  stat_hit,  32'd0);
    check32("dir_stat_miss", stat_miss, 32'd0);
`endif

    // Reset asserted while the refill request is pending.
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h0000_0040;
    k = 0;
    while (!bus.mem_rd_req && k < 50) begin
      cyc();
      k++;
    end
    check32("t5_rd_req_seen", 32'(bus.mem_rd_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check32("t5_rd_req",    32'(bus.mem_rd_req), 32'd0);
    check32("t5_wr_req",    32'(bus.mem_wr_req), 32'd0);
    check32("t5_mem_addr",  32'(bus.mem_addr),   32'd0);
    check32("t5_cpu_rdata", bus.cpu_rdata,       32'd0);
    check32("t5_cpu_miss",  32'(bus.cpu_miss),   32'd1);
    check32("t5_stat_hit",  stat_hit,            32'd0);
    check32("t5_stat_miss", stat_miss,           32'd0);
    bus.cpu_req = 1'b0;
    #1;
    check32("t5_idle_miss", 32'(bus.cpu_miss), 32'd0);
    cyc();
    rst = 1'b0;
    do_access(1'b0, 32'h0000_0004, 32'h0, rdata, missed, stall, nrd, nwr);
    check32("t5_reload_miss",  32'(missed), 32'd1);
    check32("t5_reload_rdata", rdata,       32'hDEAD_BEEF);
    check32("t5_reload_nwr",   nwr,         0);

    // Random phase from a fresh reset.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 2048; i++) golden[i] = mem[i];
    for (int s = 0; s < 4; s++) begin
      rv[s] = 1'b0;
      rdty[s] = 1'b0;
      rl[s] = '0;
    end
    exp_hits = 0;
    exp_misses = 0;
    for (int n = 0; n < 150; n++) begin
      logic [5:0]  tg;
      logic [1:0]  st;
      logic [2:0]  wd;
      logic [7:0]  ln;
      logic [31:0] a;
      logic [31:0] wv;
      logic        we;
      bit          emiss;
      bit          ewb;
      tg = 6'($urandom_range(0, 3));
      st = 2'($urandom_range(0, 3));
      wd = 3'($urandom_range(0, 7));
      a = $urandom();
      a[12:2] = {tg, st, wd};
      wv = $urandom();
      we = 1'($urandom_range(0, 1));
      ln = {tg, st};
      emiss = !(rv[st] && rl[st] == ln);
      ewb = emiss && rv[st] && rdty[st];
      do_access(we, a, wv, rdata, missed, stall, nrd, nwr);
      check32($sformatf("rnd%0d_miss", n), 32'(missed), 32'(emiss));
      check32($sformatf("rnd%0d_nrd", n), nrd, emiss ? 1 : 0);
      check32($sformatf("rnd%0d_nwr", n), nwr, ewb ? 1 : 0);
      if (ewb && nwr == 1) begin
        check32($sformatf("rnd%0d_wb_addr", n), 32'(last_wr_addr), 32'(rl[st]));
        for (int w = 0; w < 8; w++)
          check32($sformatf("rnd%0d_wb_w%0d", n, w), last_wr_line[w], golden[{rl[st], 3'(w)}]);
      end
      if (emiss) begin
        exp_misses++;
        rdty[st] = 1'b0;
      end else begin
        exp_hits++;
      end
      rv[st] = 1'b1;
      rl[st] = ln;
      if (we) begin
        golden[{ln, wd}] = wv;
        rdty[st] = 1'b1;
      end else begin
        check32($sformatf("rnd%0d_rdata", n), rdata, golden[{ln, wd}]);
      end
      repeat ($urandom_range(0, 2)) begin
        bus.cpu_addr = $urandom();
        #1;
        check32($sformatf("rnd%0d_gap_miss", n), 32'(bus.cpu_miss), 32'd0);
        cyc();
      end
    end

`ifdef CACHE_STATS_EN
    check32("rnd_stat_hit",  stat_hit,  exp_hits);
    check32("rnd_stat_miss", stat_miss, exp_misses);
`else
    check32("rnd_stat_hit",  stat_hit,  32'd0);
    check32("rnd_stat_miss", stat_miss, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
